ip_dma_cpu_debug_mem: RTL and testbench

Debug-memory controller for the IP_DMA Nios II debug path. Sits directly downstream of the debug slave wrapper's system-clock side. It executes the wrapper's `take_action_ocimem_*` command pulses and `jdo` payload against an on-chip debug RAM, then returns `MonDReg`, `monitor_ready` and `monitor_error` to the wrapper. A CPU-side Avalon-MM slave port shares the same RAM; JTAG commands have priority over it.

---
 rtl/ip_dma_cpu_debug_mem_if.sv | 43 ++++
 rtl/ip_dma_cpu_debug_mem.sv | 229 ++++++++++++++++++++++
 tb/tb_ip_dma_cpu_debug_mem.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_dma_cpu_debug_mem_if.sv
// ----------------------------------------------------------------------------
// ip_dma_cpu_debug_mem_if
// Bus bundle between the debug-memory controller and its two clients:
//   - JTAG side (debug slave wrapper, system-clock half):
//       jdo[37:0], take_action_ocimem_a/b, take_no_action_ocimem_a   -> ctrl
//       MonDReg[31:0], monitor_ready, monitor_error                  <- ctrl
//   - CPU side (Avalon-MM slave):
//       avs_address, avs_read, avs_write, avs_writedata              -> ctrl
//       avs_readdata, avs_waitrequest                                <- ctrl
// modport slave  : the controller's view.
// modport master : the view of whatever drives the commands (wrapper/CPU/bench).
// ----------------------------------------------------------------------------
interface ip_dma_cpu_debug_mem_if #(
  parameter int ADDR_W = 9
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport slave (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input  avs_address, avs_read, avs_write, avs_writedata,
    output MonDReg, monitor_ready, monitor_error,
    output avs_readdata, avs_waitrequest
  );

  modport master (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output avs_address, avs_read, avs_write, avs_writedata,
    input  MonDReg, monitor_ready, monitor_error,
    input  avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/ip_dma_cpu_debug_mem.sv
// ----------------------------------------------------------------------------
// ip_dma_cpu_debug_mem
// Debug-memory controller for the IP_DMA Nios II debug path. Executes the JTAG
// wrapper's set-address / write / read-next pulses against an on-chip debug
// RAM and shares the same RAM with a CPU-side Avalon-MM slave port. JTAG
// commands win arbitration whenever the FSM is idle.
// Ports:
//   clk      system clock (single domain)
//   reset_n  asynchronous active-low reset
//   bus      ip_dma_cpu_debug_mem_if.slave (JTAG command/monitor + Avalon-MM)
// ----------------------------------------------------------------------------
module ip_dma_cpu_debug_mem #(
  parameter int ADDR_W    = 9,
  parameter int MEM_WORDS = 256
) (
  input  logic                          clk,
  input  logic                          reset_n,
  ip_dma_cpu_debug_mem_if.slave         bus
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_J_RD   = 3'd1,
    S_J_CAP  = 3'd2,
    S_C_RD   = 3'd3,
    S_C_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    JP_NONE = 2'd0,
    JP_RD   = 2'd1,
    JP_WR   = 2'd2
  } jpend_t;

  // Word addresses at or above MEM_WORDS have no backing storage.
  function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
    return (int'(addr) < MEM_WORDS);
  endfunction

  // Storage and registers
  logic [31:0]       r_mem [MEM_WORDS];
  logic [31:0]       r_ram_q;
  state_t            r_state;
  jpend_t            r_jpend;
  logic [31:0]       r_jwdata;
  logic [ADDR_W-1:0] r_jaddr;
  logic              r_rd_oor;
  logic [31:0]       r_mon_dreg;
  logic              r_mon_ready;
  logic              r_mon_error;
  logic [31:0]       r_avs_readdata;

  // Combinational nets
  logic              w_set, w_wr, w_rn, w_multi, w_set_rd;
  logic              w_want_q, w_full, w_queue, w_drop, w_wr_acc;
  logic              w_jrd_start, w_jwr_exec, w_crd_start, w_cwr_exec;
  logic              w_jconsume, w_jcap;
  logic              w_ram_we, w_ram_re;
  logic [ADDR_W-1:0] w_ram_waddr, w_ram_raddr;
  logic [31:0]       w_ram_wdata;
  logic              w_err_set;
  logic              w_waitreq;
  state_t            w_state_nxt;
  logic              w_unused_jdo;

  // Pulse decode: set-address beats write beats read-next; a full slot drops
  // anything that wants to queue.
  always_comb begin
    w_set    = bus.take_action_ocimem_a;
    w_wr     = bus.take_action_ocimem_b & ~bus.take_action_ocimem_a;
    w_rn     = bus.take_no_action_ocimem_a & ~bus.take_action_ocimem_a & ~bus.take_action_ocimem_b;
    w_multi  = (bus.take_action_ocimem_a & (bus.take_action_ocimem_b | bus.take_no_action_ocimem_a)) |
               (bus.take_action_ocimem_b & bus.take_no_action_ocimem_a);
    w_set_rd = w_set & bus.jdo[34];
    w_want_q = w_set_rd | w_wr | w_rn;
    w_full   = (r_jpend != JP_NONE);
    w_queue  = w_want_q & ~w_full;
    w_drop   = w_want_q & w_full;
    w_wr_acc = w_wr & ~w_full;
  end

  // FSM next state and per-cycle action strobes; JTAG is only considered in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_jrd_start = 1'b0;
    w_jwr_exec  = 1'b0;
    w_crd_start = 1'b0;
    w_cwr_exec  = 1'b0;
    w_jconsume  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_jpend == JP_RD) begin
          w_jrd_start = 1'b1;
          w_jconsume  = 1'b1;
          w_state_nxt = S_J_RD;
        end else if (r_jpend == JP_WR) begin
          w_jwr_exec  = 1'b1;
          w_jconsume  = 1'b1;
        end else if (r_jpend != JP_NONE) begin
          // Unencoded slot value: flush it so the slot cannot stay stuck full.
          w_jconsume  = 1'b1;
        end else if (bus.avs_read) begin
          w_crd_start = 1'b1;
          w_state_nxt = S_C_RD;
        end else if (bus.avs_write) begin
          w_cwr_exec  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_J_RD:   w_state_nxt = S_J_CAP;
      S_J_CAP:  w_state_nxt = S_IDLE;
      S_C_RD:   w_state_nxt = S_C_DONE;
      S_C_DONE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // RAM port muxing, error sources and CPU stall.
  always_comb begin
    w_jcap      = (r_state == S_J_CAP);
    w_ram_waddr = w_jwr_exec ? r_jaddr : bus.avs_address;
    w_ram_wdata = w_jwr_exec ? r_jwdata : bus.avs_writedata;
    w_ram_we    = (w_jwr_exec & f_in_range(r_jaddr)) |
                  (w_cwr_exec & f_in_range(bus.avs_address));
    w_ram_re    = w_jrd_start | w_crd_start;
    w_ram_raddr = w_jrd_start ? r_jaddr : bus.avs_address;
    w_err_set   = w_multi | w_drop |
                  (w_jwr_exec & ~f_in_range(r_jaddr)) |
                  (w_jcap & r_rd_oor);
    // A read is released only in C_DONE; a write only when it executes now.
    w_waitreq   = (bus.avs_read & (r_state != S_C_DONE)) |
                  (bus.avs_write & ~w_cwr_exec);
    w_unused_jdo = ^{bus.jdo[37:35], bus.jdo[2:0]};
  end

  // Debug RAM: single write port, registered read port, contents not reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_waddr[IDX_W-1:0]] <= w_ram_wdata;
    end
    if (w_ram_re) begin
      r_ram_q <= r_mem[w_ram_raddr[IDX_W-1:0]];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending JTAG command slot and its write data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jpend  <= JP_NONE;
      r_jwdata <= 32'd0;
    end else if (w_queue) begin
      r_jpend  <= w_wr ? JP_WR : JP_RD;
      r_jwdata <= w_wr ? bus.jdo[34:3] : r_jwdata;
    end else if (w_jconsume) begin
      r_jpend  <= JP_NONE;
    end
  end

  // JTAG address: a set-address pulse overrides the post-access increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jaddr <= '0;
    end else if (w_set) begin
      r_jaddr <= bus.jdo[17 +: ADDR_W];
    end else if (w_jwr_exec | w_jcap) begin
      r_jaddr <= r_jaddr + ADDR_W'(1);
    end
  end

  // Out-of-range flag of the read in flight (JTAG or CPU; never both).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_oor <= 1'b0;
    end else if (w_ram_re) begin
      r_rd_oor <= ~f_in_range(w_ram_raddr);
    end
  end

  // JTAG monitor outputs; a new error beats the clear from set-address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mon_dreg  <= 32'd0;
      r_mon_ready <= 1'b0;
      r_mon_error <= 1'b0;
    end else begin
      if (w_jcap) begin
        r_mon_dreg <= r_rd_oor ? 32'd0 : r_ram_q;
      end
      if (w_set | w_wr_acc) begin
        r_mon_ready <= 1'b0;
      end else if (w_jwr_exec | w_jcap) begin
        r_mon_ready <= 1'b1;
      end
      if (w_err_set) begin
        r_mon_error <= 1'b1;
      end else if (w_set) begin
        r_mon_error <= 1'b0;
      end
    end
  end

  // CPU read data register, loaded once the RAM output has settled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_avs_readdata <= 32'd0;
    end else if (r_state == S_C_RD) begin
      r_avs_readdata <= r_rd_oor ? 32'd0 : r_ram_q;
    end
  end

  assign bus.MonDReg         = r_mon_dreg;
  assign bus.monitor_ready   = r_mon_ready;
  assign bus.monitor_error   = r_mon_error;
  assign bus.avs_readdata    = r_avs_readdata;
  assign bus.avs_waitrequest = w_waitreq;

endmodule

// File: tb/tb_ip_dma_cpu_debug_mem.sv
// ----------------------------------------------------------------------------
// tb_ip_dma_cpu_debug_mem
// Randomised bench with a command-level reference model. JTAG commands push a
// time-stamped expected monitor snapshot; CPU reads push expected read data.
// A monitor process compares these whenever they fall due / the DUT releases
// a read.
// ----------------------------------------------------------------------------
module tb_ip_dma_cpu_debug_mem;
  localparam int ADDR_W    = 9;
  localparam int MEM_WORDS = 256;
  localparam int ASPACE    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  ip_dma_cpu_debug_mem_if #(.ADDR_W(ADDR_W)) bus ();

  ip_dma_cpu_debug_mem #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory image, JTAG address, visible monitor state.
  logic [31:0] m_mem [ASPACE];
  int          m_jaddr;
  logic [31:0] m_dreg;
  logic        m_rdy;
  logic        m_err;

  typedef struct {
    int          due;
    logic [31:0] dreg;
    logic        rdy;
    logic        err;
  } jexp_t;

  jexp_t       jq[$];
  logic [31:0] cq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void push_j(input int due);
    jq.push_back('{due: due, dreg: m_dreg, rdy: m_rdy, err: m_err});
  endfunction

  function automatic logic [37:0] rand_jdo();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[37:0];
  endfunction

  function automatic logic [37:0] mk_set(input int addr, input logic rd);
    logic [37:0] d;
    d = rand_jdo();
    d[17 +: ADDR_W] = ADDR_W'(addr);
    d[34] = rd;
    return d;
  endfunction

  function automatic logic [37:0] mk_wr(input logic [31:0] data);
    logic [37:0] d;
    d = rand_jdo();
    d[34:3] = data;
    return d;
  endfunction

  function automatic void model_read();
    if (m_jaddr < MEM_WORDS) begin
      m_dreg = m_mem[m_jaddr];
    end else begin
      m_dreg = 32'd0;
      m_err  = 1'b1;
    end
    m_rdy   = 1'b1;
    m_jaddr = (m_jaddr + 1) % ASPACE;
  endfunction

  // Command effect with the slot empty; reads finish 3 edges after the pulse,
  // everything else 1 edge after.
  function automatic void model_jtag(input logic a, input logic b, input logic n,
                                     input logic [37:0] d, input int k, output bit is_rd);
    logic multi;
    multi = (a & (b | n)) | (b & n);
    is_rd = 1'b0;
    if (a) begin
      m_jaddr = int'(d[17 +: ADDR_W]);
      m_rdy   = 1'b0;
      m_err   = multi;
      if (d[34]) begin
        model_read();
        is_rd = 1'b1;
      end
    end else if (b) begin
      if (m_jaddr < MEM_WORDS) m_mem[m_jaddr] = d[34:3];
      else m_err = 1'b1;
      if (multi) m_err = 1'b1;
      m_jaddr = (m_jaddr + 1) % ASPACE;
      m_rdy   = 1'b1;
    end else if (n) begin
      model_read();
      is_rd = 1'b1;
    end
    push_j(is_rd ? k + 3 : k + 1);
  endfunction

  // Monitor: JTAG snapshots on their due cycle, CPU data on each released read.
  always @(negedge clk) begin
    jexp_t e;
    if (jq.size() > 0 && jq[0].due <= cyc) begin
      e = jq.pop_front();
      check("MonDReg", bus.MonDReg, e.dreg);
      check("monitor_ready", bus.monitor_ready, e.rdy);
      check("monitor_error", bus.monitor_error, e.err);
    end
    if (bus.avs_read && !bus.avs_waitrequest) begin
      if (cq.size() == 0) begin
        n_checks++;
        $display("FAIL avs_unexpected_read: got readdata 0x%0h, expected no completion", bus.avs_readdata);
      end else begin
        check("avs_readdata", bus.avs_readdata, cq.pop_front());
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic jtag_pulse(input logic a, input logic b, input logic n,
                            input logic [37:0] d, output int k);
    bus.jdo                     = d;
    bus.take_action_ocimem_a    = a;
    bus.take_action_ocimem_b    = b;
    bus.take_no_action_ocimem_a = n;
    k = cyc + 1;
    @(posedge clk);
    #1;
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.jdo                     = rand_jdo();
  endtask

  task automatic jcmd(input logic a, input logic b, input logic n, input logic [37:0] d);
    int k;
    bit r;
    jtag_pulse(a, b, n, d, k);
    model_jtag(a, b, n, d, k, r);
    idle(r ? 3 : 1);
  endtask

  task automatic cpu_write(input int addr, input logic [31:0] data, input int exp_waits);
    int waits;
    waits = 0;
    bus.avs_address   = ADDR_W'(addr);
    bus.avs_writedata = data;
    bus.avs_write     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.avs_waitrequest) break;
      waits++;
    end
    @(posedge clk);
    #1;
    bus.avs_write = 1'b0;
    check("cpu_write_waits", waits, exp_waits);
    if (addr < MEM_WORDS) m_mem[addr] = data;
  endtask

  task automatic cpu_read(input int addr, input int exp_waits);
    int waits;
    waits = 0;
    cq.push_back((addr < MEM_WORDS) ? m_mem[addr] : 32'd0);
    bus.avs_address = ADDR_W'(addr);
    bus.avs_read    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.avs_waitrequest) break;
      waits++;
    end
    @(posedge clk);
    #1;
    bus.avs_read = 1'b0;
    check("cpu_read_waits", waits, exp_waits);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k1;
    int k2;
    int op;
    int a;
    bit r;

    bus.jdo = 38'd0;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.avs_address = '0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = 32'd0;
    m_jaddr = 0;
    m_dreg = 32'd0;
    m_rdy = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < ASPACE; i++) m_mem[i] = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("reset_MonDReg", bus.MonDReg, 32'd0);
    check("reset_monitor_ready", bus.monitor_ready, 1'b0);
    check("reset_monitor_error", bus.monitor_error, 1'b0);
    check("reset_avs_readdata", bus.avs_readdata, 32'd0);
    check("reset_waitrequest", bus.avs_waitrequest, 1'b0);
    idle(1);

    // Give every implemented word a known value
    for (int i = 0; i < MEM_WORDS; i++) cpu_write(i, $urandom, 0);

    // Set-address 5, write, read back; then read-next proves jaddr = 6
    jcmd(1'b1, 1'b0, 1'b0, mk_set(5, 1'b0));
    jcmd(1'b0, 1'b1, 1'b0, mk_wr(32'h1234_5678));
    jcmd(1'b1, 1'b0, 1'b0, mk_set(5, 1'b1));
    jcmd(1'b0, 1'b0, 1'b1, rand_jdo());

    // CPU fills 10..12, JTAG walks them with read-next
    cpu_write(10, 32'h0000_000A, 0);
    cpu_write(11, 32'h0000_000B, 0);
    cpu_write(12, 32'h0000_000C, 0);
    jcmd(1'b1, 1'b0, 1'b0, mk_set(10, 1'b0));
    repeat (3) jcmd(1'b0, 1'b0, 1'b1, rand_jdo());

    // Out-of-range JTAG read, then set-address clears the error
    jcmd(1'b1, 1'b0, 1'b0, mk_set(300, 1'b1));
    jcmd(1'b1, 1'b0, 1'b0, mk_set(7, 1'b0));

    // CPU read alone, then behind a pending JTAG read
    cpu_read(3, 2);
    jtag_pulse(1'b1, 1'b0, 1'b0, mk_set(40, 1'b1), k1);
    model_jtag(1'b1, 1'b0, 1'b0, mk_set(40, 1'b1), k1, r);
    cpu_read(3, 5);
    idle(1);

    // CPU write stalls one cycle behind a pending JTAG write
    jtag_pulse(1'b0, 1'b1, 1'b0, mk_wr(32'hCAFE_0041), k1);
    model_jtag(1'b0, 1'b1, 1'b0, mk_wr(32'hCAFE_0041), k1, r);
    cpu_write(50, 32'h5A5A_0050, 1);
    idle(1);

    // Second pulse while the slot is full is dropped
    jtag_pulse(1'b1, 1'b0, 1'b0, mk_set(20, 1'b1), k1);
    jtag_pulse(1'b0, 1'b0, 1'b1, rand_jdo(), k2);
    m_jaddr = 20;
    m_rdy   = 1'b0;
    m_err   = 1'b1;
    push_j(k2 + 1);
    m_dreg  = m_mem[20];
    m_rdy   = 1'b1;
    m_jaddr = 21;
    push_j(k1 + 3);
    idle(2);

    // Write and read-next in the same cycle: write wins, error set
    jcmd(1'b1, 1'b0, 1'b0, mk_set(30, 1'b0));
    jcmd(1'b0, 1'b1, 1'b1, mk_wr(32'hDEAD_BEEF));
    jcmd(1'b0, 1'b0, 1'b1, rand_jdo());

    // Word 511 is out of range; jaddr wraps to 0
    jcmd(1'b1, 1'b0, 1'b0, mk_set(511, 1'b0));
    jcmd(1'b0, 1'b1, 1'b0, mk_wr(32'h0BAD_0511));
    jcmd(1'b0, 1'b0, 1'b1, rand_jdo());
    jcmd(1'b1, 1'b0, 1'b0, mk_set(0, 1'b0));

    // Random mix of CPU and JTAG traffic
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 4);
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(MEM_WORDS, ASPACE - 1)
                                       : $urandom_range(0, MEM_WORDS - 1);
      case (op)
        0: cpu_write(a, $urandom, 0);
        1: cpu_read(a, 2);
        2: jcmd(1'b1, 1'b0, 1'b0, mk_set(a, 1'($urandom_range(0, 1))));
        3: jcmd(1'b0, 1'b1, 1'($urandom_range(0, 3) == 0), mk_wr($urandom));
        default: jcmd(1'b0, 1'b0, 1'b1, rand_jdo());
      endcase
    end

    // Make sure the monitor outputs are nonzero before the reset test
    cpu_write(5, 32'h0000_5555, 0);
    cpu_read(5, 2);
    jcmd(1'b1, 1'b0, 1'b0, mk_set(5, 1'b1));

    // Reset during J_RD: the pending read is lost
    jtag_pulse(1'b1, 1'b0, 1'b0, mk_set(6, 1'b1), k1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_MonDReg", bus.MonDReg, 32'd0);
    check("midreset_monitor_ready", bus.monitor_ready, 1'b0);
    check("midreset_monitor_error", bus.monitor_error, 1'b0);
    check("midreset_avs_readdata", bus.avs_readdata, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_jaddr = 0;
    m_dreg  = 32'd0;
    m_rdy   = 1'b0;
    m_err   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("postreset_no_late_ready", bus.monitor_ready, 1'b0);
    end
    idle(1);
    jcmd(1'b0, 1'b0, 1'b1, rand_jdo());
    cpu_read(0, 2);

    idle(5);
    check("scoreboard_drained", jq.size() + cq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
